// File: rtl/mnd_sched_pkg.sv
// Shared encodings for the multiply/divide scheduler:
// E-stage opcodes, unit op types, HI/LO write selects, FSM states.
package mnd_sched_pkg;

  localparam logic [3:0] EOP_NONE  = 4'd0;
  localparam logic [3:0] EOP_MULT  = 4'd1;
  localparam logic [3:0] EOP_MULTU = 4'd2;
  localparam logic [3:0] EOP_DIV   = 4'd3;
  localparam logic [3:0] EOP_DIVU  = 4'd4;
  localparam logic [3:0] EOP_MFHI  = 4'd5;
  localparam logic [3:0] EOP_MFLO  = 4'd6;
  localparam logic [3:0] EOP_MTHI  = 4'd7;
  localparam logic [3:0] EOP_MTLO  = 4'd8;

  // Unit op types share the EOp codes so EOp can be forwarded as-is.
  localparam logic [3:0] MND_TYPE_DEFAULT = 4'd0;
  localparam logic [3:0] MND_MULT         = EOP_MULT;
  localparam logic [3:0] MND_MULTU        = EOP_MULTU;
  localparam logic [3:0] MND_DIV          = EOP_DIV;
  localparam logic [3:0] MND_DIVU         = EOP_DIVU;

  localparam logic [1:0] MND_WE_NONE    = 2'd0;
  localparam logic [1:0] MND_WRITE_HI   = 2'd1;
  localparam logic [1:0] MND_WRITE_LO   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MULBUSY = 2'd1,
    ST_DIVBUSY = 2'd2
  } state_e;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == EOP_MULT) || (op == EOP_MULTU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == EOP_DIV) || (op == EOP_DIVU);
  endfunction

endpackage

// File: rtl/mnd_sched.sv
// Multiply/divide issue scheduler: starts the unit, tracks its
// latency, and stalls E while a HI/LO user waits on a busy unit.
module mnd_sched
  import mnd_sched_pkg::*;
#(
  parameter int MULLAT = 5,
  parameter int DIVLAT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       requestInt,
  input  logic [3:0] EOp,
  output logic       start,
  output logic [3:0] MNDType,
  output logic [1:0] MNDWE,
  output logic       stallE,
  output logic       busy,
  output logic       done
);

  localparam int MAXLAT = (MULLAT > DIVLAT) ? MULLAT : DIVLAT;
  localparam int CW     = $clog2(MAXLAT) + 1;

  localparam logic [CW-1:0] MUL_END = CW'(MULLAT);
  localparam logic [CW-1:0] DIV_END = CW'(DIVLAT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          idle;
  logic          issue;
  logic          last;

  // Issue decision, end-of-op detection and next state/count.
  always_comb begin
    idle    = (state_q == ST_IDLE);
    issue   = (is_mul(EOp) || is_div(EOp)) && idle && !requestInt;
    last    = ((state_q == ST_MULBUSY) && (cnt_q == MUL_END)) ||
              ((state_q == ST_DIVBUSY) && (cnt_q == DIV_END));
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!requestInt) begin
      if (idle) begin
        if (issue) begin
          state_d = is_mul(EOp) ? ST_MULBUSY : ST_DIVBUSY;
          cnt_d   = CNT_ONE;
        end
      end else if (last) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // State and latency counter; reset wins even mid-operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs, all forced quiet while reset is held.
  always_comb begin
    start   = !reset && issue;
    MNDType = start ? EOp : MND_TYPE_DEFAULT;
    MNDWE   = MND_WE_NONE;
    if (!reset && idle && !requestInt) begin
      if (EOp == EOP_MTHI) MNDWE = MND_WRITE_HI;
      if (EOp == EOP_MTLO) MNDWE = MND_WRITE_LO;
    end
    stallE  = !reset && (EOp != EOP_NONE) && !idle;
    busy    = !reset && !idle;
    done    = !reset && last && !requestInt;
  end

endmodule

// File: tb/tb_mnd_sched.sv
// Randomized and directed bench for mnd_sched against a
// remaining-cycles reference model.
module tb_mnd_sched;
  import mnd_sched_pkg::*;

  localparam int MULLAT = 5;
  localparam int DIVLAT = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       requestInt;
  logic [3:0] EOp;
  logic       start;
  logic [3:0] MNDType;
  logic [1:0] MNDWE;
  logic       stallE;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  int rem   = 0;
  int cyc   = 0;
  int busy_cnt;
  int stall_cnt;
  int done_at;
  int start_at;

  mnd_sched #(.MULLAT(MULLAT), .DIVLAT(DIVLAT)) dut (
    .clk(clk), .reset(reset), .requestInt(requestInt), .EOp(EOp),
    .start(start), .MNDType(MNDType), .MNDWE(MNDWE),
    .stallE(stallE), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // One cycle: drive, check outputs mid-cycle, advance model at edge.
  task automatic step(input logic [3:0] op, input logic rq,
                      input logic rs);
    bit md, e_start, e_busy, e_done, e_stall;
    int e_we;
    EOp = op; requestInt = rq; reset = rs;
    md = (op >= 4'd1 && op <= 4'd4);
    @(negedge clk);
    if (rs) begin
      e_start = 0; e_busy = 0; e_done = 0; e_stall = 0; e_we = 0;
    end else begin
      e_busy  = rem > 0;
      e_done  = (rem == 1) && !rq;
      e_stall = (op != 4'd0) && (rem > 0);
      e_start = (rem == 0) && md && !rq;
      e_we    = 0;
      if (rem == 0 && !rq) begin
        if (op == 4'd7) e_we = 1;
        if (op == 4'd8) e_we = 2;
      end
    end
    chk("start",  int'(start),   int'(e_start));
    chk("type",   int'(MNDType), e_start ? int'(op) : 0);
    chk("we",     int'(MNDWE),   e_we);
    chk("stall",  int'(stallE),  int'(e_stall));
    chk("busy",   int'(busy),    int'(e_busy));
    chk("done",   int'(done),    int'(e_done));
    if (busy) busy_cnt++;
    if (stallE) stall_cnt++;
    if (done) done_at = cyc;
    if (start) start_at = cyc;
    @(posedge clk);
    if (rs) rem = 0;
    else if (rq) rem = rem;
    else if (rem > 0) rem--;
    else if (e_start) rem = (op <= 4'd2) ? MULLAT : DIVLAT;
    cyc++;
    #1;
  endtask

  task automatic clear_stats();
    busy_cnt = 0; stall_cnt = 0; done_at = -1; start_at = -1; cyc = 0;
  endtask

  initial begin
    reset = 1'b1; requestInt = 1'b0; EOp = EOP_NONE;
    @(posedge clk); #1;
    step(EOP_MULT, 1'b0, 1'b1);
    step(EOP_NONE, 1'b0, 1'b1);

    // Mult in cycle 0, NONE afterwards: never stalls.
    clear_stats();
    step(EOP_MULT, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(EOP_NONE, 1'b0, 1'b0);
    chk("mul_busy_len", busy_cnt, MULLAT);
    chk("mul_done_at", done_at, MULLAT);
    chk("none_nostall", stall_cnt, 0);

    // Div then MFLO waiting: stalled for the whole div.
    clear_stats();
    step(EOP_DIV, 1'b0, 1'b0);
    for (int i = 0; i < DIVLAT; i++) step(EOP_MFLO, 1'b0, 1'b0);
    step(EOP_MFLO, 1'b0, 1'b0);
    chk("mflo_stall_len", stall_cnt, DIVLAT);

    // MULTU, then DIVU arriving in the done cycle.
    clear_stats();
    step(EOP_MULTU, 1'b0, 1'b0);
    for (int i = 0; i < MULLAT - 1; i++) step(EOP_NONE, 1'b0, 1'b0);
    step(EOP_DIVU, 1'b0, 1'b0);
    step(EOP_DIVU, 1'b0, 1'b0);
    for (int i = 0; i < DIVLAT + 1; i++) step(EOP_NONE, 1'b0, 1'b0);
    chk("divu_start_at", start_at, MULLAT + 1);
    chk("b2b_busy_len", busy_cnt, MULLAT + DIVLAT);

    // Div interrupted at cnt=4 for two cycles, MTHI with interrupt.
    clear_stats();
    step(EOP_DIV, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(EOP_NONE, 1'b0, 1'b0);
    step(EOP_NONE, 1'b1, 1'b0);
    step(EOP_NONE, 1'b1, 1'b0);
    for (int i = 0; i < DIVLAT; i++) step(EOP_NONE, 1'b0, 1'b0);
    chk("div_done_delay", done_at, DIVLAT + 2);
    step(EOP_MTHI, 1'b1, 1'b0);
    step(EOP_MTHI, 1'b0, 1'b0);

    // Reset mid-mult, then MTLO accepted at once.
    step(EOP_MULT, 1'b0, 1'b0);
    step(EOP_NONE, 1'b0, 1'b0);
    step(EOP_NONE, 1'b0, 1'b0);
    step(EOP_NONE, 1'b0, 1'b1);
    step(EOP_MTLO, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] op;
      op = (($urandom_range(0, 2)) == 0) ? EOP_NONE
                                         : 4'($urandom_range(0, 8));
      step(op, ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
